// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Runs an external 4-bit up/down, decimal/hex counter through one commanded
//   run. The block clears the counter and lets it count until the target value
//   has been hit the requested number of times. It then freezes the counter on
//   the target and pulses done.
//
//   State table:
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for a command; counter paused; cmd_ready high
//   S_CLEAR | one cycle: counter cleared to 0 at the next edge
//   S_RUN   | counter stepping; hits on target counted
//   S_DONE  | one cycle: counter frozen on target; done follows
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in S_IDLE)
//   cmd_mode              1 = hex, 0 = decimal
//   cmd_incr              1 = up, 0 = down
//   cmd_target            terminal value
//   cmd_laps              target hits required (0 means 1)
//   hold                  user pause, honoured only in S_RUN
//   abort                 cancels a run in progress
//   cnt_value             counter output
//   cnt_clear/mode/incr/pause   counter controls
//   busy                  state != S_IDLE
//   lap_count             hits counted in the current or last run
//   done/aborted/err      one-cycle registered status pulses
module counter_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_mode,
    input  logic       cmd_incr,
    input  logic [3:0] cmd_target,
    input  logic [3:0] cmd_laps,
    input  logic       hold,
    input  logic       abort,
    input  logic [3:0] cnt_value,
    output logic       cnt_clear,
    output logic       cnt_mode,
    output logic       cnt_incr,
    output logic       cnt_pause,
    output logic       busy,
    output logic [3:0] lap_count,
    output logic       done,
    output logic       aborted,
    output logic       err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_nxt;

    logic       mode_r;
    logic       incr_r;
    logic [3:0] target_r;
    logic [3:0] laps_r;
    logic       step_prev;

    logic       accept;
    logic       cmd_illegal;
    logic       abort_act;
    logic       hit;
    logic       final_hit;
    logic [4:0] eff_laps;

    assign accept      = cmd_valid && (state == S_IDLE);
    assign cmd_illegal = !cmd_mode && (cmd_target > 4'd9);
    assign abort_act   = abort && (state != S_IDLE);
    assign eff_laps    = (laps_r == 4'd0) ? 5'd1 : {1'b0, laps_r};

    // A hit counts only on a value freshly produced by a counter step. A held
    // or first-RUN cycle leaves step_prev low, so sitting on the target is
    // never counted twice.
    assign hit       = (state == S_RUN) && step_prev && (cnt_value == target_r);
    assign final_hit = hit && (({1'b0, lap_count} + 5'd1) == eff_laps);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign cnt_clear = (state == S_CLEAR);
    assign cnt_mode  = mode_r;
    assign cnt_incr  = incr_r;

    always_comb begin
        state_nxt = state;
        cnt_pause = 1'b1;
        case (state)
            S_IDLE: begin
                if (accept && !cmd_illegal)
                    state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                cnt_pause = 1'b0;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // final_hit pauses in the same cycle so the counter stays on target
                cnt_pause = hold || final_hit;
                if (final_hit)
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // abort overrides everything, including a final hit in the same cycle
        if (abort_act) begin
            state_nxt = S_IDLE;
            cnt_pause = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            mode_r    <= 1'b0;
            incr_r    <= 1'b0;
            target_r  <= 4'd0;
            laps_r    <= 4'd0;
            lap_count <= 4'd0;
            step_prev <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_nxt;
            step_prev <= (state == S_RUN) && !cnt_pause;
            done      <= (state == S_DONE) && !abort_act;
            aborted   <= abort_act;
            err       <= accept && cmd_illegal;
            if (accept && !cmd_illegal) begin
                mode_r    <= cmd_mode;
                incr_r    <= cmd_incr;
                target_r  <= cmd_target;
                laps_r    <= cmd_laps;
                lap_count <= 4'd0;
            end else if (hit && !abort_act) begin
                lap_count <= lap_count + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_mode;
    logic       cmd_incr;
    logic [3:0] cmd_target;
    logic [3:0] cmd_laps;
    logic       hold;
    logic       abort;
    logic [3:0] cnt_value;
    logic       cnt_clear;
    logic       cnt_mode;
    logic       cnt_incr;
    logic       cnt_pause;
    logic       busy;
    logic [3:0] lap_count;
    logic       done;
    logic       aborted;
    logic       err;

    int total = 0;
    int bad   = 0;

    counter_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_mode   (cmd_mode),
        .cmd_incr   (cmd_incr),
        .cmd_target (cmd_target),
        .cmd_laps   (cmd_laps),
        .hold       (hold),
        .abort      (abort),
        .cnt_value  (cnt_value),
        .cnt_clear  (cnt_clear),
        .cnt_mode   (cnt_mode),
        .cnt_incr   (cnt_incr),
        .cnt_pause  (cnt_pause),
        .busy       (busy),
        .lap_count  (lap_count),
        .done       (done),
        .aborted    (aborted),
        .err        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Environment model of the universal counter the sequencer drives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_value <= 4'd0;
        else if (cnt_clear)
            cnt_value <= 4'd0;
        else if (!cnt_pause) begin
            if (cnt_incr)
                cnt_value <= (!cnt_mode && cnt_value == 4'd9) ? 4'd0 : cnt_value + 4'd1;
            else
                cnt_value <= (!cnt_mode && cnt_value == 4'd0) ? 4'd9 : cnt_value - 4'd1;
        end
    end

    // kind: 0 = done, 1 = aborted, 2 = err
    typedef struct {
        int         kind;
        int         lat;
        logic [3:0] val;
        logic [3:0] laps;
        bit         chk;
    } exp_t;

    exp_t exp_q[$];

    int cyc       = 0;
    int acc_cyc   = 0;
    int clear_cnt = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cmd_valid && cmd_ready)
            acc_cyc = cyc;
        if (cnt_clear)
            clear_cnt = clear_cnt + 1;
    end

    // Scoreboard monitor: pops one expectation per status pulse.
    always @(negedge clk) begin
        if (!rst && (done || aborted || err)) begin
            int   kind;
            exp_t e;
            kind = done ? 0 : (aborted ? 1 : 2);
            if (done + aborted + err > 1)
                kind = 7;
            total = total + 1;
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_pulse: kind=%0d with no expectation", kind);
            end else begin
                e = exp_q.pop_front();
                if (kind != e.kind) begin
                    bad = bad + 1;
                    $display("FAIL pulse_kind: got %0d want %0d", kind, e.kind);
                end
                total = total + 1;
                if (cyc - acc_cyc != e.lat) begin
                    bad = bad + 1;
                    $display("FAIL pulse_latency: got %0d want %0d", cyc - acc_cyc, e.lat);
                end
                if (e.chk) begin
                    total = total + 1;
                    if (cnt_value != e.val) begin
                        bad = bad + 1;
                        $display("FAIL final_value: got %0d want %0d", cnt_value, e.val);
                    end
                    total = total + 1;
                    if (lap_count != e.laps) begin
                        bad = bad + 1;
                        $display("FAIL lap_count: got %0d want %0d", lap_count, e.laps);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        total = total + 1;
        if (got !== want) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic expect_pulse(input int kind, input int lat, input logic [3:0] val,
                                input logic [3:0] laps, input bit chk);
        exp_t e;
        e.kind = kind;
        e.lat  = lat;
        e.val  = val;
        e.laps = laps;
        e.chk  = chk;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic mode, input logic incr, input logic [3:0] target,
                        input logic [3:0] laps);
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_mode   = mode;
        cmd_incr   = incr;
        cmd_target = target;
        cmd_laps   = laps;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL timeout_%s: %0d expectations pending want 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_value(input logic [3:0] v, input string name);
        int n;
        n = 0;
        while (!(busy && !cnt_clear && cnt_value == v) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL timeout_%s: value %0d never seen", name, v);
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_mode   = 1'b0;
        cmd_incr   = 1'b0;
        cmd_target = 4'd0;
        cmd_laps   = 4'd0;
        hold       = 1'b0;
        abort      = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_busy", {3'b0, busy}, 4'd0);
        check("rst_cmd_ready", {3'b0, cmd_ready}, 4'd1);
        check("rst_cnt_pause", {3'b0, cnt_pause}, 4'd1);
        check("rst_cnt_clear", {3'b0, cnt_clear}, 4'd0);
        check("rst_lap_count", lap_count, 4'd0);
        rst = 1'b0;
        @(negedge clk);

        // hex up, target 5, 1 lap: 5 steps -> done 8 cycles after accept
        expect_pulse(0, 8, 4'd5, 4'd1, 1'b1);
        send(1'b1, 1'b1, 4'd5, 4'd1);
        wait_drained("hex_up_5");
        check("hex_up_5_frozen", cnt_value, 4'd5);

        // decimal down, target 7, 2 laps: 3 + 10 steps -> 16
        expect_pulse(0, 16, 4'd7, 4'd2, 1'b1);
        send(1'b0, 1'b0, 4'd7, 4'd2);
        wait_drained("dec_down_7");
        check("dec_down_7_frozen", cnt_value, 4'd7);

        // decimal up, target 0, no hold: full wrap, 10 steps -> 13
        expect_pulse(0, 13, 4'd0, 4'd1, 1'b1);
        send(1'b0, 1'b1, 4'd0, 4'd1);
        wait_drained("dec_up_0");

        // same run with 3 hold cycles at value 4 -> 16
        expect_pulse(0, 16, 4'd0, 4'd1, 1'b1);
        send(1'b0, 1'b1, 4'd0, 4'd1);
        wait_value(4'd4, "hold_at_4");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_value", cnt_value, 4'd4);
        end
        hold = 1'b0;
        wait_drained("dec_up_0_hold");

        // laps 0 behaves as 1: hex up target 3 -> 6
        expect_pulse(0, 6, 4'd3, 4'd1, 1'b1);
        send(1'b1, 1'b1, 4'd3, 4'd0);
        wait_drained("laps_zero");

        // abort in the final-hit cycle, then an immediate new command
        expect_pulse(1, 4, 4'd2, 4'd0, 1'b0);
        send(1'b1, 1'b1, 4'd2, 4'd1);
        wait_value(4'd2, "abort_hit");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", {3'b0, busy}, 4'd0);
        check("abort_done", {3'b0, done}, 4'd0);
        check("abort_value", cnt_value, 4'd2);
        expect_pulse(0, 6, 4'd3, 4'd1, 1'b1);
        cmd_valid  = 1'b1;
        cmd_mode   = 1'b1;
        cmd_incr   = 1'b1;
        cmd_target = 4'd3;
        cmd_laps   = 4'd1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        check("abort_reaccept_busy", {3'b0, busy}, 4'd1);
        wait_drained("after_abort");

        // illegal decimal target 12 -> err, no clear, latches unchanged
        clear_cnt = 0;
        expect_pulse(2, 0, 4'd0, 4'd0, 1'b0);
        send(1'b0, 1'b0, 4'd12, 4'd1);
        wait_drained("illegal");
        check("illegal_no_clear", (clear_cnt == 0) ? 4'd0 : 4'd1, 4'd0);
        check("illegal_busy", {3'b0, busy}, 4'd0);
        check("illegal_mode_kept", {3'b0, cnt_mode}, 4'd1);
        check("illegal_incr_kept", {3'b0, cnt_incr}, 4'd1);

        // asynchronous reset mid-run, between edges
        send(1'b0, 1'b1, 4'd9, 4'd3);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", {3'b0, busy}, 4'd0);
        check("async_rst_pause", {3'b0, cnt_pause}, 4'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {3'b0, cmd_ready}, 4'd1);
        check("post_rst_laps", lap_count, 4'd0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
